uart_tx_fsm: RTL

Frame sequencer for the UART transmit path. Accepts a parallel byte with a one-cycle valid strobe and drives the serializer's `load`/`ser_en` controls. Computes and latches the parity bit and muxes start, data, parity and stop bits onto the line. Every `CLK` edge is one bit period; the clock is already at baud rate.

---
 rtl/uart_tx_fsm.sv | 93 +++++++++
 1 files changed

// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: start, LSB-first data via serializer, optional parity, stop; START follows accept by one cycle.
// No buffering: DATA_VALID is taken only in IDLE or STOP, and upstream holds off while BUSY is high.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  load,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_par_bit;
  logic   r_par_en;
  logic   w_accept;

  // Gated by RST so a request during reset never pulses load.
  assign w_accept = RST && DATA_VALID && ((r_state == IDLE) || (r_state == STOP));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_par_bit <= (^P_DATA) ^ PAR_TYP;
        r_par_en  <= PAR_EN;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    load   = w_accept;
    ser_en = 1'b0;
    TX_OUT = 1'b1;
    BUSY   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = START;
      end
      START: begin
        TX_OUT = 1'b0;
        BUSY   = 1'b1;
        w_next = DATA;
      end
      DATA: begin
        ser_en = 1'b1;
        TX_OUT = ser_data;
        BUSY   = 1'b1;
        if (ser_done) w_next = r_par_en ? PARITY : STOP;
      end
      PARITY: begin
        TX_OUT = r_par_bit;
        BUSY   = 1'b1;
        w_next = STOP;
      end
      STOP: begin
        BUSY   = 1'b1;
        w_next = w_accept ? START : IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    // Line goes idle-high in the same cycle reset is applied, not at the next edge.
    if (!RST) begin
      ser_en = 1'b0;
      TX_OUT = 1'b1;
      BUSY   = 1'b0;
    end
  end

endmodule
